// File: rtl/axis_master_pkg.sv
// Shared types and default sizing for the multi-channel AXIS master mux.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package axis_master_pkg;

    localparam int DEF_N_CH        = 4;
    localparam int DW              = 32;
    localparam int KW              = DW / 8;
    localparam int UW              = 2;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_RDY_TIMEOUT = 5;
    localparam int PTR_W           = $clog2(DEF_DEPTH) + 1;
    localparam int NORDY_W         = 8;

    // Channel-id width; a single channel still gets a 1-bit tid.
    function automatic int tid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TID_W = tid_w(DEF_N_CH);

`ifdef AXIS_MST_PKT_LOCK_EN
    typedef enum logic [1:0] {IDLE, SEND, LOCK} mux_state_e;
`else
    typedef enum logic [1:0] {IDLE, SEND} mux_state_e;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] strb;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

endpackage

// File: rtl/axis_master_mux_if.sv
// Bundle of backend-side and AXIS-side signals of the mux.
// Latency: n/a (wiring only).
// Backpressure: bk_ready per channel, axis_tready on the stream side.
interface axis_master_mux_if
    import axis_master_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
);
    localparam int TW = tid_w(N_CH);

    logic [N_CH-1:0]    bk_valid;
    logic [N_CH-1:0]    bk_ready;
    logic [N_CH*DW-1:0] bk_data;
    logic [N_CH*KW-1:0] bk_tstrb;
    logic [N_CH*KW-1:0] bk_tkeep;
    logic [N_CH*UW-1:0] bk_user;
    logic [N_CH-1:0]    bk_last;
    logic [N_CH-1:0]    bk_clear;
    logic               bk_nordy;
    logic               axis_tvalid;
    logic [DW-1:0]      axis_tdata;
    logic [KW-1:0]      axis_tstrb;
    logic [KW-1:0]      axis_tkeep;
    logic [UW-1:0]      axis_tuser;
    logic [TW-1:0]      axis_tid;
    logic               axis_tlast;
    logic               axis_tready;

    // The mux itself: drives the AXIS stream and the backend ready lines.
    modport master (
        input  bk_valid, bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last, bk_clear, axis_tready,
        output bk_ready, bk_nordy, axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep,
               axis_tuser, axis_tid, axis_tlast
    );

    // The surroundings: backends plus the AXIS sink.
    modport slave (
        output bk_valid, bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last, bk_clear, axis_tready,
        input  bk_ready, bk_nordy, axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep,
               axis_tuser, axis_tid, axis_tlast
    );

endinterface

// File: rtl/axis_mst_chan_fifo.sv
// Per-channel synchronous FIFO of beats; all DEPTH entries usable, synchronous clear.
// Latency: no fall-through; a beat written at edge N is readable after edge N.
// Backpressure: wr_rdy_o = !full & !clear from registered pointers, low while in/just out of reset.
module axis_mst_chan_fifo
    import axis_master_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  logic  wr_vld_i,
    output logic  wr_rdy_o,
    input  beat_t wr_dat_i,
    input  logic  rd_en_i,
    output beat_t rd_dat_o,
    input  logic  clear_i,
    output logic  empty_o,
    output logic  full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PONE = PW'(1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          en_q;
    beat_t         mem_q [DEPTH];
    logic          wr_fire, rd_fire;

    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    // en_q keeps ready low during reset and for the first edge after release.
    assign wr_rdy_o = en_q && !full_o && !clear_i;
    assign wr_fire  = wr_vld_i && wr_rdy_o;
    assign rd_fire  = rd_en_i && !empty_o;
    assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next state; clear wins over a read and blocks the write via wr_rdy_o.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + PONE;
            if (rd_fire) rd_ptr_d = rd_ptr_q + PONE;
        end
    end

    // Pointer and enable registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            en_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            en_q     <= 1'b1;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end

endmodule

// File: rtl/axis_master_mux.sv
// N_CH backend FIFOs drained round-robin into one registered AXIS output tagged with axis_tid.
// Latency: FIFO write at edge N reaches the output register at edge N+1 at the earliest; 1 beat/cycle.
// Backpressure: output held while tvalid & !tready; bk_nordy after RDY_TIMEOUT stalls; AXIS_MST_PKT_LOCK_EN keeps packets contiguous.
module axis_master_mux
    import axis_master_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int RDY_TIMEOUT = DEF_RDY_TIMEOUT
) (
    input logic               axi_aclk,
    input logic               axi_aresetn,
    axis_master_mux_if.master bus
);
    localparam int TW = tid_w(N_CH);

    beat_t           fifo_dat [N_CH];
    logic [N_CH-1:0] empty, full, rd_en, elig, wr_rdy;
    logic            gnt_vld, load;
    logic [TW-1:0]   gnt;
    logic [TW-1:0]   rr_q, rr_d;
    beat_t           beat_q, beat_d;
    logic [TW-1:0]   tid_q, tid_d;
    logic            tvalid_q, tvalid_d;
    logic [NORDY_W-1:0] cnt_q, cnt_d;
    mux_state_e      state_q, state_d, load_state;
`ifdef AXIS_MST_PKT_LOCK_EN
    logic [TW-1:0]   lock_ch_q;
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        beat_t wr_beat;
        assign wr_beat = '{data: bus.bk_data[c*DW +: DW],
                           strb: bus.bk_tstrb[c*KW +: KW],
                           keep: bus.bk_tkeep[c*KW +: KW],
                           user: bus.bk_user[c*UW +: UW],
                           last: bus.bk_last[c]};
        assign rd_en[c] = load && (gnt == TW'(c));

        axis_mst_chan_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk_i    (axi_aclk),
            .rst_n_i  (axi_aresetn),
            .wr_vld_i (bus.bk_valid[c]),
            .wr_rdy_o (wr_rdy[c]),
            .wr_dat_i (wr_beat),
            .rd_en_i  (rd_en[c]),
            .rd_dat_o (fifo_dat[c]),
            .clear_i  (bus.bk_clear[c]),
            .empty_o  (empty[c]),
            .full_o   (full[c])
        );

        a_full_blocks_wr: assert property (@(posedge axi_aclk) disable iff (!axi_aresetn)
            full[c] |-> !wr_rdy[c]);
    end

    assign bus.bk_ready = wr_rdy;

    // Eligibility: non-empty, not being flushed, and (when locked) the locked channel only.
    always_comb begin
        elig = '0;
        for (int c = 0; c < N_CH; c++) begin
            elig[c] = !empty[c] && !bus.bk_clear[c];
`ifdef AXIS_MST_PKT_LOCK_EN
            if (state_q == LOCK && lock_ch_q != TW'(c)) elig[c] = 1'b0;
`endif
        end
    end

    // Round-robin search; rr_q holds the channel after the last grant (0 after reset).
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt     = TW'(idx);
            end
        end
    end

    assign load = (!tvalid_q || bus.axis_tready) && gnt_vld;

    // Output register, rr pointer and stall counter next state.
    always_comb begin
        beat_d   = beat_q;
        tid_d    = tid_q;
        tvalid_d = tvalid_q;
        rr_d     = rr_q;
        if (load) begin
            beat_d   = fifo_dat[gnt];
            tid_d    = gnt;
            tvalid_d = 1'b1;
            rr_d     = (gnt == TW'(N_CH - 1)) ? '0 : gnt + TW'(1);
        end else if (bus.axis_tready) begin
            tvalid_d = 1'b0;
        end
        if (tvalid_q && !bus.axis_tready)
            cnt_d = (cnt_q == {NORDY_W{1'b1}}) ? cnt_q : cnt_q + NORDY_W'(1);
        else
            cnt_d = '0;
    end

    // FSM next state: SEND while a beat is held, LOCK while a packet is open.
    always_comb begin
`ifdef AXIS_MST_PKT_LOCK_EN
        load_state = fifo_dat[gnt].last ? SEND : LOCK;
`else
        load_state = SEND;
`endif
        state_d = state_q;
        case (state_q)
            IDLE: if (load) state_d = load_state;
            SEND: begin
                if (load)                  state_d = load_state;
                else if (bus.axis_tready)  state_d = IDLE;
            end
`ifdef AXIS_MST_PKT_LOCK_EN
            LOCK: begin
                if (bus.bk_clear[lock_ch_q])          state_d = tvalid_d ? SEND : IDLE;
                else if (load && fifo_dat[gnt].last)  state_d = SEND;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, output register, rr pointer and stall counter.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            tid_q    <= '0;
            tvalid_q <= 1'b0;
            rr_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            tid_q    <= tid_d;
            tvalid_q <= tvalid_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef AXIS_MST_PKT_LOCK_EN
    // Remember which channel opened the current packet.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn)  lock_ch_q <= '0;
        else if (load)     lock_ch_q <= gnt;
    end
`endif

    assign bus.axis_tvalid = tvalid_q;
    assign bus.axis_tdata  = beat_q.data;
    assign bus.axis_tstrb  = beat_q.strb;
    assign bus.axis_tkeep  = beat_q.keep;
    assign bus.axis_tuser  = beat_q.user;
    assign bus.axis_tlast  = beat_q.last;
    assign bus.axis_tid    = tid_q;
    assign bus.bk_nordy    = (cnt_q >= NORDY_W'(RDY_TIMEOUT));

endmodule

// File: tb/tb_axis_master_mux.sv
// Bench for axis_master_mux: queue-based reference model checked every cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: tready patterns driven by the directed tests.
module tb_axis_master_mux;
    import axis_master_pkg::*;

    localparam int NC = 4;
    localparam int DP = 8;
    localparam int TO = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_master_mux_if #(.N_CH(NC)) bus();

    axis_master_mux #(.N_CH(NC), .DEPTH(DP), .RDY_TIMEOUT(TO)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .bus         (bus)
    );

    logic [NC-1:0] vld, clr, last;
    logic [31:0]   dv [NC];
    logic          trdy;

    always_comb begin
        bus.bk_valid    = vld;
        bus.bk_clear    = clr;
        bus.bk_last     = last;
        bus.axis_tready = trdy;
        bus.bk_data     = '0;
        bus.bk_tstrb    = '0;
        bus.bk_tkeep    = '0;
        bus.bk_user     = '0;
        for (int c = 0; c < NC; c++) begin
            bus.bk_data[c*32 +: 32] = dv[c];
            bus.bk_tstrb[c*4 +: 4]  = dv[c][3:0];
            bus.bk_tkeep[c*4 +: 4]  = dv[c][7:4];
            bus.bk_user[c*2 +: 2]   = dv[c][9:8];
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mkbeat(input int c);
        beat_t b;
        b.data = dv[c];
        b.strb = dv[c][3:0];
        b.keep = dv[c][7:4];
        b.user = dv[c][9:8];
        b.last = last[c];
        return b;
    endfunction

    // ---------------- reference model (queues, per-edge rules) ----------------
    beat_t mq [NC][$];
    beat_t m_beat;
    logic  m_vld;
    int    m_tid, m_start, m_cnt;
    logic  m_alive;
`ifdef AXIS_MST_PKT_LOCK_EN
    logic  m_lock;
    int    m_lock_ch;
`endif

    initial begin
        int g, c;
        logic pre_vld;
        logic [NC-1:0] acc;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NC; i++) mq[i].delete();
                m_beat = '0; m_vld = 1'b0; m_tid = 0; m_start = 0; m_cnt = 0; m_alive = 1'b0;
`ifdef AXIS_MST_PKT_LOCK_EN
                m_lock = 1'b0; m_lock_ch = 0;
`endif
            end else begin
                pre_vld = m_vld;
                for (int i = 0; i < NC; i++)
                    acc[i] = vld[i] && m_alive && (mq[i].size() < DP) && !clr[i];
                g = -1;
                if (!m_vld || trdy) begin
                    for (int k = 0; k < NC; k++) begin
                        c = (m_start + k) % NC;
                        if (g < 0 && mq[c].size() > 0 && !clr[c]
`ifdef AXIS_MST_PKT_LOCK_EN
                            && (!m_lock || c == m_lock_ch)
`endif
                           ) g = c;
                    end
                    if (g >= 0) begin
                        m_beat  = mq[g].pop_front();
                        m_tid   = g;
                        m_vld   = 1'b1;
                        m_start = (g + 1) % NC;
`ifdef AXIS_MST_PKT_LOCK_EN
                        m_lock    = !m_beat.last;
                        m_lock_ch = g;
`endif
                    end else begin
                        m_vld = 1'b0;
                    end
                end
                for (int i = 0; i < NC; i++) begin
                    if (clr[i]) begin
                        mq[i].delete();
`ifdef AXIS_MST_PKT_LOCK_EN
                        if (m_lock && m_lock_ch == i) m_lock = 1'b0;
`endif
                    end
                end
                for (int i = 0; i < NC; i++) if (acc[i]) mq[i].push_back(mkbeat(i));
                m_cnt   = (pre_vld && !trdy) ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 0;
                m_alive = 1'b1;
            end
        end
    end

    // ---------------- compare + monitor, away from the active edge ----------------
    int cyc = 0;
    int obs_tid [$];
    int obs_dat [$];
    int obs_cyc [$];
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_tvalid", bus.axis_tvalid, 0);
                chk("rst_tdata",  bus.axis_tdata, 0);
                chk("rst_tid",    bus.axis_tid, 0);
                chk("rst_ready",  bus.bk_ready, 0);
                chk("rst_nordy",  bus.bk_nordy, 0);
            end else begin
                chk("tvalid", bus.axis_tvalid, m_vld);
                if (m_vld) begin
                    chk("tdata", bus.axis_tdata, m_beat.data);
                    chk("tstrb", bus.axis_tstrb, m_beat.strb);
                    chk("tkeep", bus.axis_tkeep, m_beat.keep);
                    chk("tuser", bus.axis_tuser, m_beat.user);
                    chk("tlast", bus.axis_tlast, m_beat.last);
                    chk("tid",   bus.axis_tid, m_tid);
                end
                for (int i = 0; i < NC; i++)
                    chk($sformatf("bk_ready%0d", i), bus.bk_ready[i],
                        m_alive && (mq[i].size() < DP) && !clr[i]);
                chk("nordy", bus.bk_nordy, m_cnt >= TO);
                if (bus.axis_tvalid && bus.axis_tready) begin
                    obs_tid.push_back(int'(bus.axis_tid));
                    obs_dat.push_back(int'(bus.axis_tdata));
                    obs_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clr_obs();
        obs_tid.delete();
        obs_dat.delete();
        obs_cyc.delete();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int seq, acc_n, n2;
        logic r;
        vld = '0; clr = '0; last = '0; trdy = 1'b0;
        for (int i = 0; i < NC; i++) dv[i] = '0;
        step(2);
        rst_n = 1'b1;
        step(2);

        // 1: reset mid-burst
        trdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vld[0] = 1'b1; dv[0] = 32'h100 + i; last[0] = 1'b0;
            step(1);
        end
        chk("t1_pre_rst_tvalid", bus.axis_tvalid, 1);
        chk("t1_pre_rst_tdata", bus.axis_tdata, 32'h100);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_tvalid_now", bus.axis_tvalid, 0);
        chk("t1_rst_tdata_now", bus.axis_tdata, 0);
        vld = '0;
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("t1_empty_after_rst", bus.axis_tvalid, 0);
        clr_obs();

        // 2: four channels at once
        vld = 4'hF; last = 4'hF;
        for (int i = 0; i < NC; i++) dv[i] = 32'h200 + i;
        step(1);
        vld = '0;
        step(6);
        chk("t2_count", obs_tid.size(), 4);
        if (obs_tid.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t2_tid_order", obs_tid[i], i);
            chk("t2_contiguous", obs_cyc[3] - obs_cyc[0], 3);
        end
        clr_obs();

        // 3: ch1 fills while tready=0
        trdy = 1'b0; seq = 0; acc_n = 0;
        for (int i = 0; i < 12; i++) begin
            vld[1] = 1'b1; dv[1] = 32'h300 + seq; last[1] = 1'b1;
            r = bus.bk_ready[1];
            step(1);
            if (r) begin acc_n++; seq++; end
        end
        vld = '0;
        chk("t3_accepted", acc_n, DP + 1);
        chk("t3_nordy", bus.bk_nordy, 1);
        chk("t3_ready_full", bus.bk_ready[1], 0);
        trdy = 1'b1;
        step(12);
        chk("t3_delivered", obs_dat.size(), DP + 1);
        for (int i = 0; i < obs_dat.size(); i++) chk("t3_order", obs_dat[i], 32'h300 + i);
        clr_obs();

        // 4: toggling tready over 0xA0..0xA7
        seq = 0;
        for (int i = 0; i < 40; i++) begin
            trdy   = (i % 2 == 0);
            vld[0] = (seq < 8);
            dv[0]  = 32'hA0 + seq;
            last[0] = (seq == 7);
            r = bus.bk_ready[0] && vld[0];
            step(1);
            if (r) seq++;
        end
        vld = '0; trdy = 1'b1;
        step(6);
        chk("t4_count", obs_dat.size(), 8);
        for (int i = 0; i < obs_dat.size(); i++) chk("t4_order", obs_dat[i], 32'hA0 + i);
        clr_obs();

        // 5: flush ch2 with a write in the same cycle
        trdy = 1'b0; seq = 0;
        for (int i = 0; i < 10 && seq < 5; i++) begin
            vld[2] = 1'b1; dv[2] = 32'h500 + seq; last[2] = 1'b1;
            r = bus.bk_ready[2];
            step(1);
            if (r) seq++;
        end
        chk("t5_filled", seq, 5);
        clr[2] = 1'b1; vld[2] = 1'b1; dv[2] = 32'hDEAD;
        #1;
        chk("t5_ready_in_clear", bus.bk_ready[2], 0);
        step(1);
        clr = '0; vld = '0;
        step(1);
        trdy = 1'b1;
        step(8);
        n2 = 0;
        for (int i = 0; i < obs_tid.size(); i++) if (obs_tid[i] == 2) n2++;
        chk("t5_ch2_beats", n2, 1);
        if (obs_dat.size() > 0) chk("t5_held_beat", obs_dat[0], 32'h500);
        clr_obs();

        // 6: 3-beat packet on ch0 racing a single beat on ch1
        vld = 4'b0011;
        dv[0] = 32'h600; last[0] = 1'b0;
        dv[1] = 32'h610; last[1] = 1'b1;
        step(1);
        vld = 4'b0001; dv[0] = 32'h601; last[0] = 1'b0;
        step(1);
        dv[0] = 32'h602; last[0] = 1'b1;
        step(1);
        vld = '0;
        step(6);
        chk("t6_count", obs_tid.size(), 4);
        if (obs_tid.size() == 4) begin
`ifdef AXIS_MST_PKT_LOCK_EN
            chk("t6_tid0", obs_tid[0], 0); chk("t6_tid1", obs_tid[1], 0);
            chk("t6_tid2", obs_tid[2], 0); chk("t6_tid3", obs_tid[3], 1);
`else
            chk("t6_tid0", obs_tid[0], 0); chk("t6_tid1", obs_tid[1], 1);
            chk("t6_tid2", obs_tid[2], 0); chk("t6_tid3", obs_tid[3], 0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
